// File: rtl/rcv.sv
// rcv: 8N1 UART receiver with a 16x oversampled majority-vote bit decision,
// a ready/charack byte handshake and sticky framing/overrun flags.
module rcv #(
   parameter logic        IDLELEVEL  = 1'b1,
   parameter logic        DATAINV    = 1'b0,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned CLOCK      = 12_000_000,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxpin,
   input  logic       charack,
   output logic [7:0] char,
   output logic       ready,
   output logic       framerr,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned DIV = (CLOCK + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
   localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned SW  = $clog2(OVERSAMPLE);
   localparam int unsigned M   = OVERSAMPLE / 2;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITIDLE} state_t;

   state_t          state_q, state_d;
   logic [1:0]      sync_q;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [SW-1:0]   sub_q, sub_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      sh_q, sh_d;
   logic            v0_q, v0_d, v1_q, v1_d;
   logic [7:0]      char_d;
   logic            ready_d, framerr_d, overrun_d, busy_d;
   logic            rx, tick, mid, wrap, vote;

   assign rx   = sync_q[1];
   assign tick = (tcnt_q == TW'(DIV - 1));
   assign mid  = tick && (sub_q == SW'(M + 1));
   assign wrap = tick && (sub_q == SW'(OVERSAMPLE - 1));
   assign vote = (v0_q & v1_q) | (v0_q & rx) | (v1_q & rx);

   // Two-flop synchronizer for the (optionally inverted) serial input
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= {IDLELEVEL, IDLELEVEL};
      end else begin
         sync_q <= {sync_q[0], rxpin ^ DATAINV};
      end
   end

   // State, counters, shift register and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         tcnt_q  <= '0;
         sub_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         char    <= 8'h00;
         ready   <= 1'b0;
         framerr <= 1'b0;
         overrun <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         sub_q   <= sub_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         v0_q    <= v0_d;
         v1_q    <= v1_d;
         char    <= char_d;
         ready   <= ready_d;
         framerr <= framerr_d;
         overrun <= overrun_d;
         busy    <= busy_d;
      end
   end

   // Next-state, sampling and handshake logic
   always_comb begin
      state_d   = state_q;
      tcnt_d    = tcnt_q;
      sub_d     = sub_q;
      bit_d     = bit_q;
      sh_d      = sh_q;
      v0_d      = v0_q;
      v1_d      = v1_q;
      char_d    = char;
      ready_d   = ready;
      framerr_d = framerr;
      overrun_d = overrun;

      if (charack) begin
         ready_d   = 1'b0;
         framerr_d = 1'b0;
         overrun_d = 1'b0;
      end

      // Tick and sub-bit timing only runs while a frame is being sampled
      if (state_q == START || state_q == DATA || state_q == STOP) begin
         tcnt_d = tick ? '0 : tcnt_q + TW'(1);
         if (tick) begin
            sub_d = wrap ? '0 : sub_q + SW'(1);
            if (sub_q == SW'(M - 1)) v0_d = rx;
            if (sub_q == SW'(M))     v1_d = rx;
         end
      end

      case (state_q)
         IDLE: begin
            tcnt_d = '0;
            sub_d  = '0;
            if (rx != IDLELEVEL) state_d = START;
         end
         START: begin
            if (mid && vote == IDLELEVEL) begin
               state_d = IDLE;
            end else if (wrap) begin
               state_d = DATA;
               bit_d   = 3'd0;
            end
         end
         DATA: begin
            if (mid) sh_d = {vote, sh_q[7:1]};
            if (wrap) begin
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         STOP: begin
            if (mid) begin
               if (vote == IDLELEVEL) begin
                  char_d  = sh_q;
                  if (ready && !charack) overrun_d = 1'b1;
                  ready_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  framerr_d = 1'b1;
                  state_d   = WAITIDLE;
               end
            end
         end
         WAITIDLE: begin
            if (rx == IDLELEVEL) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_rcv.sv
// tb_rcv: directed bench for rcv. Three instances share clk/reset:
// 0 = defaults (1248-clock bits), 1 = fast baud (64-clock bits),
// 2 = fast baud with IDLELEVEL=0, DATAINV=1.
module tb_rcv;

   localparam int DB = 1248;
   localparam int FB = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] pins;
   logic [2:0] ack;
   logic [7:0] chr [3];
   logic [2:0] rdy, fer, ovr, bsy;
   int         checks = 0;
   int         errors = 0;
   int         lat;
   logic [7:0] inv_vec [3];

   always #5 clk = ~clk;

   rcv u_def (
      .clk(clk), .reset(reset), .rxpin(pins[0]), .charack(ack[0]),
      .char(chr[0]), .ready(rdy[0]), .framerr(fer[0]), .overrun(ovr[0]), .busy(bsy[0])
   );

   rcv #(.BAUD(187_500)) u_fast (
      .clk(clk), .reset(reset), .rxpin(pins[1]), .charack(ack[1]),
      .char(chr[1]), .ready(rdy[1]), .framerr(fer[1]), .overrun(ovr[1]), .busy(bsy[1])
   );

   rcv #(.IDLELEVEL(1'b0), .DATAINV(1'b1), .BAUD(187_500)) u_inv (
      .clk(clk), .reset(reset), .rxpin(pins[2]), .charack(ack[2]),
      .char(chr[2]), .ready(rdy[2]), .framerr(fer[2]), .overrun(ovr[2]), .busy(bsy[2])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input int w, input string tag, input logic [7:0] c,
                            input logic r, input logic f, input logic o, input logic b);
      check_eq({tag, "_char"},    32'(chr[w]),        32'(c));
      check_eq({tag, "_ready"},   32'(rdy[2'(w)]),    32'(r));
      check_eq({tag, "_framerr"}, 32'(fer[2'(w)]),    32'(f));
      check_eq({tag, "_overrun"}, 32'(ovr[2'(w)]),    32'(o));
      check_eq({tag, "_busy"},    32'(bsy[2'(w)]),    32'(b));
   endtask

   // Hold the pin of instance w at physical level v for n clocks
   task automatic drive(input int w, input logic v, input int n);
      @(negedge clk);
      pins[2'(w)] = v;
      repeat (n - 1) @(negedge clk);
   endtask

   // One frame in logical levels, mapped to the pin by that instance's polarity
   task automatic send_frame(input int w, input logic [7:0] d, input int bitc,
                             input logic stop_good, input int stop_cyc);
      logic il, iv;
      il = (w == 2) ? 1'b0 : 1'b1;
      iv = (w == 2) ? 1'b1 : 1'b0;
      drive(w, ~il ^ iv, bitc);
      for (int i = 0; i < 8; i++) drive(w, d[i] ^ iv, bitc);
      drive(w, (stop_good ? il : ~il) ^ iv, stop_cyc);
   endtask

   task automatic pulse_ack(input int w);
      @(negedge clk);
      ack[2'(w)] = 1'b1;
      @(negedge clk);
      ack[2'(w)] = 1'b0;
   endtask

   initial begin
      pins  = 3'b111;
      ack   = 3'b000;
      reset = 1'b0;
      inv_vec[0] = 8'h00;
      inv_vec[1] = 8'hFF;
      inv_vec[2] = 8'h5A;
      repeat (3) @(negedge clk);
      for (int w = 0; w < 3; w++) check_out(w, "reset", 8'h00, 0, 0, 0, 0);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // Default rates: 0x55 and its latency from the start edge
      fork
         send_frame(0, 8'h55, DB, 1'b1, DB);
         begin
            lat = 0;
            while (!rdy[0] && lat < 14000) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      check_eq("lat55_window", 32'(lat >= 11700 && lat <= 12200), 32'd1);
      check_out(0, "rx55", 8'h55, 1, 0, 0, 0);
      pulse_ack(0);
      check_eq("ack55_ready", 32'(rdy[0]), 32'd0);

      // Start-bit glitch of 300 clocks
      @(negedge clk);
      pins[0] = 1'b0;
      repeat (100) @(negedge clk);
      check_eq("glitch_busy", 32'(bsy[0]), 32'd1);
      repeat (200) @(negedge clk);
      pins[0] = 1'b1;
      repeat (700) @(negedge clk);
      check_out(0, "glitch_end", 8'h55, 0, 0, 0, 0);

      // Framing error: stop held low for 3 bits, then recovery with 0x3C
      send_frame(1, 8'hA3, FB, 1'b0, 3 * FB);
      check_out(1, "ferr", 8'h00, 0, 1, 0, 1);
      repeat (FB) @(negedge clk);
      check_eq("waitidle_hold", 32'(bsy[1]), 32'd1);
      @(negedge clk);
      pins[1] = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("waitidle_exit", 32'(bsy[1]), 32'd0);
      repeat (FB) @(negedge clk);
      send_frame(1, 8'h3C, FB, 1'b1, FB);
      check_out(1, "after_ferr", 8'h3C, 1, 1, 0, 0);
      pulse_ack(1);
      check_out(1, "ack_all", 8'h3C, 0, 0, 0, 0);

      // Back-to-back frames without acknowledge
      send_frame(1, 8'h11, FB, 1'b1, FB);
      send_frame(1, 8'h22, FB, 1'b1, FB);
      check_out(1, "overrun", 8'h22, 1, 0, 1, 0);
      pulse_ack(1);
      check_out(1, "ovr_ack", 8'h22, 0, 0, 0, 0);

      // Acknowledge coincident with completion of 0x7E while ready is set
      send_frame(1, 8'h66, FB, 1'b1, FB);
      fork
         send_frame(1, 8'h7E, FB, 1'b1, FB);
         begin
            @(negedge clk);
            repeat (618) @(negedge clk);
            ack[1] = 1'b1;
            @(negedge clk);
            ack[1] = 1'b0;
         end
      join
      check_out(1, "coincident", 8'h7E, 1, 0, 0, 0);

      // Acknowledge coincident with a framing error
      fork
         send_frame(1, 8'h00, FB, 1'b0, 2 * FB);
         begin
            @(negedge clk);
            repeat (618) @(negedge clk);
            ack[1] = 1'b1;
            @(negedge clk);
            ack[1] = 1'b0;
         end
      join
      check_out(1, "ferr_ack", 8'h7E, 0, 1, 0, 1);
      @(negedge clk);
      pins[1] = 1'b1;
      repeat (FB) @(negedge clk);
      pulse_ack(1);

      // Reset during data bit 4, then a clean 0xC9
      send_frame(1, 8'h99, FB, 1'b1, FB);
      check_out(1, "pre_rst", 8'h99, 1, 0, 0, 0);
      fork
         send_frame(1, 8'hF0, FB, 1'b1, FB);
         begin
            @(negedge clk);
            repeat (340) @(negedge clk);
            reset = 1'b0;
            #1;
            check_out(1, "rst_mid", 8'h00, 0, 0, 0, 0);
            @(negedge clk);
            reset = 1'b1;
         end
      join
      repeat (FB) @(negedge clk);
      check_out(1, "post_rst", 8'h00, 0, 0, 0, 0);
      send_frame(1, 8'hC9, FB, 1'b1, FB);
      check_out(1, "rxC9", 8'hC9, 1, 0, 0, 0);

      // Inverted polarity loopback
      for (int i = 0; i < 3; i++) begin
         send_frame(2, inv_vec[i], FB, 1'b1, FB);
         check_out(2, "inv_rx", inv_vec[i], 1, 0, 0, 0);
         pulse_ack(2);
         check_eq("inv_ack", 32'(rdy[2]), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
